// File: rtl/neuron_spike_logger.sv
// -----------------------------------------------------------------------------
// neuron_spike_logger
//
// Watches the emulated membrane voltage on every decimated sample strobe and
// detects spikes with hysteresis (thr_hi / thr_lo) and a refractory window.
// Each spike is stamped with emu_time and the inter-spike interval, then
// queued in a small FIFO that the host drains through a valid/ready port.
//
// Ports
//   emu_clk, emu_rst   : clock, synchronous active-high reset
//   enable             : detection enable (0 forces the detector to ARMED)
//   emu_dec_cmp        : sample strobe; v_in/emu_time only matter when 1
//   v_in               : signed membrane voltage
//   emu_time           : current emulation time
//   thr_hi, thr_lo     : signed spike / re-arm thresholds (thr_lo < thr_hi)
//   refr_samples       : refractory length in samples
//   rd_valid, rd_ready : FIFO head handshake
//   rd_time, rd_isi    : head entry (timestamp, interval to previous spike)
//   fifo_count         : entries held
//   drop_count         : spikes lost to a full FIFO (saturating)
//   state_dbg          : detector state (0 ARMED, 1 REFRACT, 2 ABOVE)
// -----------------------------------------------------------------------------
module neuron_spike_logger #(
    parameter int V_WIDTH    = 18,
    parameter int TIME_WIDTH = 64,
    parameter int ISI_WIDTH  = 32,
    parameter int DEPTH      = 16,
    parameter int REFR_WIDTH = 16
) (
    input  logic                        emu_clk,
    input  logic                        emu_rst,
    input  logic                        enable,
    input  logic                        emu_dec_cmp,
    input  logic signed [V_WIDTH-1:0]   v_in,
    input  logic [TIME_WIDTH-1:0]       emu_time,
    input  logic signed [V_WIDTH-1:0]   thr_hi,
    input  logic signed [V_WIDTH-1:0]   thr_lo,
    input  logic [REFR_WIDTH-1:0]       refr_samples,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [TIME_WIDTH-1:0]       rd_time,
    output logic [ISI_WIDTH-1:0]        rd_isi,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic [15:0]                 drop_count,
    output logic [1:0]                  state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        REFRACT = 2'd1,
        ABOVE   = 2'd2
    } state_t;

    // Interval saturates when the unsigned time difference does not fit.
    function automatic logic [ISI_WIDTH-1:0] sat_isi(input logic [TIME_WIDTH-1:0] diff);
        if ((diff >> ISI_WIDTH) != '0)
            return '1;
        else
            return ISI_WIDTH'(diff);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Stage 0: spike detection on the sample cycle
    // -------------------------------------------------------------------------
    state_t                  state, state_next;
    logic [REFR_WIDTH-1:0]   refr_cnt, refr_cnt_next;
    logic                    spike_p0;
    logic [ISI_WIDTH-1:0]    isi_p0;
    logic [TIME_WIDTH-1:0]   last_time;
    logic                    first_spike;

    always_comb begin
        state_next    = state;
        refr_cnt_next = refr_cnt;
        spike_p0      = 1'b0;
        if (!enable) begin
            state_next    = ARMED;
            refr_cnt_next = '0;
        end else if (emu_dec_cmp) begin
            unique case (state)
                ARMED: begin
                    if (v_in >= thr_hi) begin
                        spike_p0      = 1'b1;
                        refr_cnt_next = refr_samples;
                        state_next    = (refr_samples == '0) ? ABOVE : REFRACT;
                    end
                end
                REFRACT: begin
                    if (refr_cnt > REFR_WIDTH'(1)) begin
                        refr_cnt_next = refr_cnt - REFR_WIDTH'(1);
                    end else begin
                        refr_cnt_next = '0;
                        state_next    = ABOVE;
                    end
                end
                ABOVE: begin
                    if (v_in <= thr_lo)
                        state_next = ARMED;
                end
                default: begin
                    state_next    = ARMED;
                    refr_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state    <= ARMED;
            refr_cnt <= '0;
        end else begin
            state    <= state_next;
            refr_cnt <= refr_cnt_next;
        end
    end

    // The very first spike has no predecessor, so it reports all-ones.
    assign isi_p0 = first_spike ? '1 : sat_isi(emu_time - last_time);

    always_ff @(posedge emu_clk) begin
        if (emu_rst)
            first_spike <= 1'b1;
        else if (spike_p0)
            first_spike <= 1'b0;
    end

    // last_time tracks every spike, including ones the FIFO drops.
    always_ff @(posedge emu_clk) begin
        if (!emu_rst && spike_p0)
            last_time <= emu_time;
    end

    // -------------------------------------------------------------------------
    // Stage 1: FIFO write, registered head
    // -------------------------------------------------------------------------
    logic [TIME_WIDTH-1:0]   mem_time [DEPTH];
    logic [ISI_WIDTH-1:0]    mem_isi  [DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]        count, count_next;
    logic [TIME_WIDTH-1:0]   head_time, head_time_next;
    logic [ISI_WIDTH-1:0]    head_isi, head_isi_next;
    logic                    full, pop, push_ok, drop;

    assign full     = (count == CNT_W'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = spike_p0 & (~full | pop);
    assign drop     = spike_p0 & full & ~pop;

    assign rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // The head register preloads whatever will sit at rd_ptr after this edge.
    // When that slot is being written right now, the memory still holds stale
    // data, so the incoming entry is forwarded instead.
    always_comb begin
        head_time_next = head_time;
        head_isi_next  = head_isi;
        if (count_next != '0) begin
            if (push_ok && (wr_ptr == rd_ptr_next)) begin
                head_time_next = emu_time;
                head_isi_next  = isi_p0;
            end else begin
                head_time_next = mem_time[rd_ptr_next];
                head_isi_next  = mem_isi[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge emu_clk) begin
        if (!emu_rst && push_ok) begin
            mem_time[wr_ptr] <= emu_time;
            mem_isi[wr_ptr]  <= isi_p0;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            head_time  <= '0;
            head_isi   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            head_time <= head_time_next;
            head_isi  <= head_isi_next;
            if (drop)
                drop_count <= sat_inc16(drop_count);
        end
    end

    assign rd_time    = head_time;
    assign rd_isi     = head_isi;
    assign fifo_count = count;
    assign state_dbg  = state;

endmodule

// File: tb/tb_neuron_spike_logger.sv
// -----------------------------------------------------------------------------
// tb_neuron_spike_logger
//
// Directed and random stimulus for neuron_spike_logger. Expected FIFO entries
// are pushed to a scoreboard queue when a spike is provoked and compared
// against the head whenever it is observed.
// -----------------------------------------------------------------------------
module tb_neuron_spike_logger;

    localparam int VW = 18;
    localparam int TW = 64;
    localparam int IW = 32;
    localparam int D  = 16;
    localparam int RW = 16;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [IW-1:0] isi;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  dec;
    logic signed [VW-1:0]  v_in;
    logic [TW-1:0]         emu_time;
    logic signed [VW-1:0]  thr_hi;
    logic signed [VW-1:0]  thr_lo;
    logic [RW-1:0]         refr;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [TW-1:0]         rd_time;
    logic [IW-1:0]         rd_isi;
    logic [$clog2(D):0]    fifo_count;
    logic [15:0]           drop_count;
    logic [1:0]            state_dbg;

    always #5 clk = ~clk;

    neuron_spike_logger #(
        .V_WIDTH(VW), .TIME_WIDTH(TW), .ISI_WIDTH(IW), .DEPTH(D), .REFR_WIDTH(RW)
    ) dut (
        .emu_clk(clk),
        .emu_rst(rst),
        .enable(en),
        .emu_dec_cmp(dec),
        .v_in(v_in),
        .emu_time(emu_time),
        .thr_hi(thr_hi),
        .thr_lo(thr_lo),
        .refr_samples(refr),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_time(rd_time),
        .rd_isi(rd_isi),
        .fifo_count(fifo_count),
        .drop_count(drop_count),
        .state_dbg(state_dbg)
    );

    entry_t        q[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_drops = 0;
    bit            first = 1'b1;
    logic [TW-1:0] last_t = '0;
    logic [TW-1:0] tnow = '0;
    bit            rdy = 1'b0;
    bit            armed = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare the FIFO
    // outputs with the scoreboard, advance the scoreboard, then wait for the
    // rising edge to take effect.
    task automatic step(input int s, input int v, input int exp_spike);
        entry_t        e;
        logic [TW-1:0] diff;
        @(negedge clk);
        dec      = (s != 0);
        v_in     = VW'(v);
        rd_ready = rdy;
        emu_time = tnow;
        chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("drop_count", 64'(drop_count), 64'(exp_drops));
        if (q.size() != 0) begin
            chk("rd_time", rd_time, q[0].t);
            chk("rd_isi", 64'(rd_isi), 64'(q[0].isi));
        end
        if (rst) begin
            q.delete();
            exp_drops = 0;
            first     = 1'b1;
        end else begin
            if (rdy && q.size() != 0)
                void'(q.pop_front());
            if (exp_spike != 0) begin
                e.t = tnow;
                if (first) begin
                    e.isi = '1;
                end else begin
                    diff  = tnow - last_t;
                    e.isi = (diff > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
                end
                first  = 1'b0;
                last_t = tnow;
                if (q.size() < D)
                    q.push_back(e);
                else if (exp_drops < 16'hFFFF)
                    exp_drops++;
            end
        end
        @(posedge clk);
        #1;
        tnow = tnow + 1;
    endtask

    initial begin
        int a;
        int iv;

        rst = 1'b1; en = 1'b1; dec = 1'b0; v_in = '0; emu_time = '0;
        thr_hi = 18'sd100; thr_lo = 18'sd20; refr = 16'd3; rd_ready = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0);
        rst = 1'b0;
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst_time", rd_time, 64'd0);
        chk("rst_isi", 64'(rd_isi), 64'd0);

        // single spike after a ramp
        tnow = 490;
        step(1, 0, 0); step(1, 40, 0); step(0, 80, 0); step(1, 99, 0);
        tnow = 500;
        step(1, 150, 1);
        chk("t1_valid", 64'(rd_valid), 64'd1);
        chk("t1_time", rd_time, 64'd500);
        chk("t1_isi", 64'(rd_isi), 64'hFFFF_FFFF);
        chk("t1_state", 64'(state_dbg), 64'd1);

        // refractory and hysteresis
        for (int i = 0; i < 9; i++) begin
            step(1, 150, 0);
            chk("plateau_state", 64'(state_dbg), (i < 2) ? 64'd1 : 64'd2);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 50, 0);
            chk("mid_state", 64'(state_dbg), 64'd2);
        end
        step(0, 5, 0);
        chk("nostrobe_low", 64'(state_dbg), 64'd2);
        for (int i = 0; i < 3; i++) begin
            step(1, 150, 0);
            chk("third_plateau", 64'(state_dbg), 64'd2);
        end
        step(1, 10, 0);
        chk("rearm_state", 64'(state_dbg), 64'd0);
        tnow = 900;
        step(1, 150, 1);
        chk("two_queued", 64'(fifo_count), 64'd2);
        rdy = 1'b1;
        step(0, 0, 0);
        chk("isi_400", 64'(rd_isi), 64'd400);
        chk("time_900", rd_time, 64'd900);
        step(0, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 10, 0);
        chk("armed_again", 64'(state_dbg), 64'd0);
        refr = 16'd0;

        // FIFO full and drops
        for (int i = 0; i < 20; i++) begin
            step(1, 150, 1);
            step(1, 10, 0);
        end
        chk("full_count", 64'(fifo_count), 64'd16);
        chk("full_drops", 64'(drop_count), 64'd4);
        rdy = 1'b1;
        step(1, 150, 1);
        chk("full_pushpop", 64'(fifo_count), 64'd16);
        chk("full_pushpop_drops", 64'(drop_count), 64'd4);
        for (int i = 0; i < 17; i++) step(0, 0, 0);
        chk("drained", 64'(fifo_count), 64'd0);
        step(1, 10, 0);

        // strobe gating and enable
        for (int i = 0; i < 3; i++) step(0, 150, 0);
        chk("gated_count", 64'(fifo_count), 64'd0);
        refr = 16'd3;
        step(1, 150, 1);
        chk("en_refract", 64'(state_dbg), 64'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 150, 0);
            chk("disabled_state", 64'(state_dbg), 64'd0);
        end
        en = 1'b1;
        step(1, 150, 1);
        chk("reenable_spike", 64'(state_dbg), 64'd1);
        step(0, 0, 0);
        rdy = 1'b0;

        // reset mid-refractory with entries queued
        refr = 16'd0;
        for (int i = 0; i < 4; i++) step(1, 10, 0);
        chk("pre_rst_armed", 64'(state_dbg), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 150, 1);
            step(1, 10, 0);
        end
        refr = 16'd3;
        step(1, 150, 1);
        chk("pre_rst_count", 64'(fifo_count), 64'd5);
        chk("pre_rst_state", 64'(state_dbg), 64'd1);
        chk("pre_rst_drops", 64'(drop_count), 64'd4);
        rst = 1'b1;
        step(1, 150, 0);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_drops", 64'(drop_count), 64'd0);
        chk("mid_rst_state", 64'(state_dbg), 64'd0);
        chk("mid_rst_time", rd_time, 64'd0);
        refr = 16'd0;
        tnow = 5000;
        step(1, 150, 1);
        chk("post_rst_isi", 64'(rd_isi), 64'hFFFF_FFFF);
        chk("post_rst_time", rd_time, 64'd5000);

        // ISI saturation and a short interval
        step(1, 10, 0);
        tnow = 64'd5000 + 64'h1_0000_0000;
        step(1, 150, 1);
        rdy = 1'b1;
        step(0, 0, 0);
        chk("sat_isi", 64'(rd_isi), 64'hFFFF_FFFF);
        chk("sat_time", rd_time, 64'd5000 + 64'h1_0000_0000);
        step(1, 10, 0);
        step(1, 150, 1);
        chk("short_isi", 64'(rd_isi), 64'd3);

        // random back-pressure against random spikes
        step(1, 10, 0);
        armed = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rdy  = (i < 500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            a    = int'($urandom_range(0, 3));
            tnow = tnow + 64'($urandom_range(0, 20));
            if (a == 0) begin
                step(0, int'($urandom_range(0, 400)), 0);
            end else if (a == 1) begin
                iv = int'($urandom_range(0, 1020)) - 1000;
                step(1, iv, 0);
                armed = 1'b1;
            end else begin
                iv = 100 + int'($urandom_range(0, 400));
                step(1, iv, armed ? 1 : 0);
                armed = 1'b0;
            end
        end
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("final_empty", 64'(fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_spike_logger.md
# neuron_spike_logger

Downstream consumer of the neuron emulation top level. It watches the emulated membrane voltage (fixed-point `V_out`) on every decimated sample strobe (`emu_dec_cmp`) and detects spikes with hysteresis and a refractory window. Each spike is stamped with `emu_time` and an inter-spike interval (ISI) and queued in a small FIFO. Host/trace logic drains the FIFO through a valid/ready port.

## Interface
Parameters:
- `V_WIDTH`, 18: signed fixed-point width of `v_in` and the thresholds (same scale as the `V_out` probe).
- `TIME_WIDTH`, 64: width of `emu_time`.
- `ISI_WIDTH`, 32: width of the ISI output.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `REFR_WIDTH`, 16: refractory counter width.

Ports:
- `emu_clk` in 1: the single clock.
- `emu_rst` in 1: reset, synchronous, active-high.
- `enable` in 1: detection enable.
- `emu_dec_cmp` in 1: sample strobe; `v_in` and `emu_time` are evaluated only in cycles where it is 1.
- `v_in` in `V_WIDTH`, signed: membrane voltage.
- `emu_time` in `TIME_WIDTH`: current emulation time.
- `thr_hi` in `V_WIDTH`, signed: spike threshold.
- `thr_lo` in `V_WIDTH`, signed: re-arm threshold (thr_lo < thr_hi is required; behaviour otherwise undefined).
- `refr_samples` in `REFR_WIDTH`: refractory length in samples.
- `rd_valid` out 1: FIFO head valid.
- `rd_ready` in 1: consumer accepts the head.
- `rd_time` out `TIME_WIDTH`: spike timestamp.
- `rd_isi` out `ISI_WIDTH`: interval to the previous spike.
- `fifo_count` out clog2(DEPTH)+1: entries held.
- `drop_count` out 16: spikes lost to a full FIFO.
- `state_dbg` out 2: FSM state, for probing.

## Operation
- FSM states: ARMED=0, REFRACT=1, ABOVE=2. All transitions happen only on sample cycles (`emu_dec_cmp`=1 and `enable`=1).
  - ARMED: `v_in >= thr_hi` → spike event. Load `refr_cnt = refr_samples`. Next state is REFRACT, or ABOVE if `refr_samples`=0.
  - REFRACT: if `refr_cnt` > 1, decrement it and stay. If `refr_cnt` = 1, set it to 0 and go to ABOVE. No spikes are detected in REFRACT.
  - ABOVE: `v_in <= thr_lo` → ARMED; otherwise stay.
- `enable`=0: FSM is forced to ARMED and `refr_cnt` to 0 on the next edge; no events are generated. FIFO and reads are unaffected.
- Spike event:
  - The entry `{time = emu_time of the sample cycle, isi}` is pushed.
  - `isi = emu_time − last_time`, saturating at 2^ISI_WIDTH−1. The subtraction is unsigned, TIME_WIDTH wide.
  - `isi` = all-ones for the first spike after reset.
  - `last_time` updates on every spike, including dropped ones.
- Comparisons are signed, full `V_WIDTH`.
- FIFO:
  - Push on a spike. Pop when `rd_valid & rd_ready`.
  - Full and no pop: the entry is dropped and `drop_count` increments, saturating at 0xFFFF.
  - Full with a simultaneous pop: the push is accepted and the count stays unchanged.
  - Empty: a pop is ignored.
  - Pointers wrap modulo `DEPTH`.

## Timing
- Spike detected in sample cycle N: the entry is written at edge N+1. `rd_valid`, `rd_time`, `rd_isi` and `fifo_count` reflect it from cycle N+1. Latency is 1 cycle.
- `rd_time` and `rd_isi` are driven from the FIFO head register. They are stable while `rd_valid`=1 and `rd_ready`=0.
- A pop at edge M shows the next head, or `rd_valid`=0, from cycle M+1.
- Throughput: one push and one pop per cycle.
- Reset (any cycle, including mid-refractory or with a full FIFO), in effect after the edge:
  - FSM=ARMED, `refr_cnt`=0.
  - FIFO empty: `rd_valid`=0, `fifo_count`=0.
  - `rd_time`=0, `rd_isi`=0, `drop_count`=0, `state_dbg`=0.
  - first-spike flag set.
  - Inputs during reset cycles are ignored.

## Test plan
- Single spike:
  - Stimulus: thr_hi=100, thr_lo=20, refr=3. v_in ramps 0→150 on strobes. Strobe at emu_time=500 with v_in=150.
  - Required: rd_valid rises the next cycle; rd_time=500; rd_isi=0xFFFFFFFF.
- Refractory and hysteresis:
  - Stimulus: hold v_in=150 for 10 samples, then 50 for 5 samples, then 150.
  - Required: exactly one spike from the first plateau (state 1 for 3 samples, then 2). No spike at 50 because it is above thr_lo. The third plateau gives no spike until v_in has first dropped ≤20.
  - Extension: drop v_in to 10, then 150 at emu_time=900 after the spike at 500. Required: second spike with rd_isi=400.
- FIFO full and drops:
  - Stimulus: DEPTH=16, rd_ready=0, 20 spikes. Required: fifo_count=16, drop_count=4.
  - Stimulus: then rd_ready=1 while a spike arrives. Required: count stays 16 and all entries pop in order.
- Strobe gating and enable:
  - Stimulus: v_in=150 with emu_dec_cmp=0. Required: no spike.
  - Stimulus: enable=0 with strobes. Required: no spike, state_dbg=0.
  - Stimulus: enable→1 with v_in=150. Required: spike on the next strobe.
- Reset mid-operation:
  - Stimulus: emu_rst in REFRACT with 5 entries queued.
  - Required: next cycle rd_valid=0, fifo_count=0, drop_count=0, state_dbg=0. The next spike reports isi=all-ones.
- Back-pressure stability:
  - Stimulus: toggle rd_ready randomly for 1000 cycles against random spikes.
  - Required: the popped sequence equals the pushed sequence minus the counted drops, and head outputs never change while valid & !ready.
